// File: rtl/cvt_arbiter_pkg.sv
// Shared types and constants for the converter arbiter: data width, requester
// limits, the in-flight tag carried alongside each conversion, and float format.
package cvt_arbiter_pkg;

  localparam int DATA_W    = 32;
  localparam int NREQ_MAX  = 8;
  localparam int TAG_IDX_W = $clog2(NREQ_MAX);

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_BIAS   = 127;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/int_to_fp.sv
// Pipelined signed 32-bit integer to IEEE-754 single converter, round to
// nearest even. LAT=1 is purely combinational; each extra cycle adds a register.
module int_to_fp
  import cvt_arbiter_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] int_i,
  output logic [DATA_W-1:0] fp_o
);

  function automatic logic [31:0] i2f(input logic [31:0] x);
    logic                 sign;
    logic [31:0]          mag;
    logic [31:0]          norm;
    logic [4:0]           msb;
    logic                 guard;
    logic                 sticky;
    logic [24:0]          rnd;
    logic [FP_EXP_W-1:0]  expo;
    logic [FP_MANT_W-1:0] frac;
    sign = x[31];
    mag  = sign ? (~x + 32'd1) : x;
    msb  = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm   = mag << (5'd31 - msb);
    guard  = norm[7];
    sticky = |norm[6:0];
    rnd    = {1'b0, norm[31:8]} + 25'(guard & (sticky | norm[8]));
    // A carry out of rounding bumps the exponent and leaves a zero fraction.
    expo   = 8'(FP_BIAS) + {3'b0, msb} + {7'b0, rnd[24]};
    frac   = rnd[24] ? rnd[23:1] : rnd[22:0];
    if (mag == '0) return '0;
    return {sign, expo, frac};
  endfunction

  logic [DATA_W-1:0] fp_c;
  assign fp_c = i2f(int_i);

  if (LAT == 1) begin : g_comb
    assign fp_o = fp_c;
  end else begin : g_pipe
    logic [DATA_W-1:0] pipe_q [LAT-1];

    // NOTE: these are data-only registers and carry no reset; whether a value
    // is meaningful is tracked by the arbiter's tag pipeline.
    always_ff @(posedge clk) begin
      pipe_q[0] <= fp_c;
      for (int s = 1; s < LAT - 1; s++) pipe_q[s] <= pipe_q[s-1];
    end

    assign fp_o = pipe_q[LAT-2];
  end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after ptr_i,
// wrapping modulo NREQ. Reports a one-hot grant, its index and whether any hit.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic [PW-1:0] cand;

  // NOTE: every output gets a default before the search so no path through
  // the loop can leave one unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/cvt_arbiter.sv
// Round-robin arbiter sharing one pipelined int_to_fp converter among NREQ
// requesters; a tag pipeline routes each result back to its issuer.
module cvt_arbiter
  import cvt_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int W    = DATA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_int,
  output logic [NREQ-1:0] req_ready,
  input  logic            hold,
  output logic [W-1:0]    cvt_int,
  input  logic [W-1:0]    cvt_fp,
  output logic [NREQ-1:0] rsp_valid,
  output logic [W-1:0]    rsp_fp,
  output logic            idle
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0]    cvt_int_q, cvt_int_d;
  tag_t            tag_q [LAT];
  tag_t            tag0_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic            fire;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_picker (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Reset and hold both suppress grants in the same cycle they are high.
  assign fire      = pick_any & ~hold & ~reset;
  assign req_ready = fire ? pick_gnt : '0;

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    cvt_int_d = cvt_int_q;
    tag0_d    = '0;
    if (fire) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pick_gnt[i]) cvt_int_d = req_int[i*W +: W];
      end
      rr_ptr_d     = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
      tag0_d.valid = 1'b1;
      tag0_d.idx   = TAG_IDX_W'(pick_idx);
    end
  end

  // NOTE: registers use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour and the tag shift is order-independent.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q  <= '0;
      cvt_int_q <= '0;
      for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      cvt_int_q <= cvt_int_d;
      tag_q[0]  <= tag0_d;
      for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  // The last tag stage lines up with the converter output for its operand.
  always_comb begin
    rsp_valid = '0;
    if (tag_q[LAT-1].valid) rsp_valid = NREQ'(1) << tag_q[LAT-1].idx;
  end

  always_comb begin
    idle = 1'b1;
    for (int s = 0; s < LAT; s++) begin
      if (tag_q[s].valid) idle = 1'b0;
    end
  end

  assign cvt_int = cvt_int_q;
  assign rsp_fp  = cvt_fp;

endmodule

// File: tb/tb_cvt_arbiter.sv
// Scoreboard bench for cvt_arbiter driving a real int_to_fp converter: grants
// are predicted by a pointer model, expected results queued and matched on rsp_valid.
module tb_cvt_arbiter;
  import cvt_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int W    = 32;
  localparam int NTAB = 12;

  localparam logic [31:0] TAB_INT [NTAB] = '{
    32'h0000_0001, 32'h0000_0000, 32'hFFFF_F884, 32'h0000_0002,
    32'h7FFF_FFFF, 32'h8000_0000, 32'h0100_0001, 32'h0100_0003,
    32'hFFFF_FFFF, 32'h0000_0064, 32'h0000_03E8, 32'h0000_0003};
  localparam logic [31:0] TAB_FP [NTAB] = '{
    32'h3F80_0000, 32'h0000_0000, 32'hC4EF_8000, 32'h4000_0000,
    32'h4F00_0000, 32'hCF00_0000, 32'h4B80_0000, 32'h4B80_0002,
    32'hBF80_0000, 32'h42C8_0000, 32'h447A_0000, 32'h4040_0000};

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_int;
  logic [NREQ-1:0]   req_ready;
  logic              hold;
  logic [W-1:0]      cvt_int;
  logic [W-1:0]      cvt_fp;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_fp;
  logic              idle;

  always #5 clk = ~clk;

  cvt_arbiter #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_int   (req_int),
    .req_ready (req_ready),
    .hold      (hold),
    .cvt_int   (cvt_int),
    .cvt_fp    (cvt_fp),
    .rsp_valid (rsp_valid),
    .rsp_fp    (rsp_fp),
    .idle      (idle)
  );

  int_to_fp #(.LAT(LAT)) u_cvt (
    .clk   (clk),
    .int_i (cvt_int),
    .fp_o  (cvt_fp)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] fp;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           cyc         = 0;
  bit           mon_en      = 1'b0;
  int           model_ptr   = 0;
  logic [W-1:0] model_cvt   = '0;
  logic [W-1:0] cur_int [NREQ];
  logic [W-1:0] cur_fp  [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  // Response checker: every rsp_valid must match the oldest outstanding entry.
  always @(negedge clk) begin
    exp_t            e;
    logic [NREQ-1:0] exp_v;
    if (mon_en) begin
      if (rsp_valid !== '0) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp: rsp_valid=%b rsp_fp=%h with nothing outstanding", rsp_valid, rsp_fp);
        end else begin
          e     = sb.pop_front();
          exp_v = NREQ'(1) << e.idx;
          if (rsp_valid !== exp_v || rsp_fp !== e.fp || cyc != e.cyc || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL rsp: got valid=%b fp=%h cyc=%0d idle=%b, expected valid=%b fp=%h cyc=%0d idle=0",
                     rsp_valid, rsp_fp, cyc, idle, exp_v, e.fp, e.cyc);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_rsp: no rsp_valid at cyc=%0d, expected requester %0d fp=%h",
                 cyc, sb[0].idx, sb[0].fp);
        void'(sb.pop_front());
      end
    end
  end

  task automatic set_int(input int r, input int t);
    req_int[r*W +: W] = TAB_INT[t];
    cur_int[r]        = TAB_INT[t];
    cur_fp[r]         = TAB_FP[t];
  endtask

  // Drives one cycle of request inputs, predicts the grant and queues the result.
  task automatic step(input logic [NREQ-1:0] v, input logic h,
                      output logic [NREQ-1:0] got, output logic [NREQ-1:0] exp_g);
    int w;
    req_valid = v;
    hold      = h;
    #1;
    got   = req_ready;
    exp_g = '0;
    w     = -1;
    if (!h) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (model_ptr + k) % NREQ;
        if (w < 0 && v[j]) w = j;
      end
    end
    if (w >= 0) begin
      exp_g[w] = 1'b1;
      sb.push_back('{idx: w, fp: cur_fp[w], cyc: cyc + LAT});
      model_ptr = (w + 1) % NREQ;
      model_cvt = cur_int[w];
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    req_valid = '0;
    n = 0;
    while (sb.size() != 0 && n < 4 * LAT + 10) begin
      @(negedge clk);
      n++;
    end
    #2;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d results still outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = '1;
    req_int   = '0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (req_ready !== '0 || idle !== 1'b1 || rsp_valid !== '0 || cvt_int !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b idle=%b rsp_valid=%b cvt_int=%h, required 0000/1/0000/0",
               req_ready, idle, rsp_valid, cvt_int);
    end
    reset     = 1'b0;
    req_valid = '0;
    model_ptr = 0;
    model_cvt = '0;
    mon_en    = 1'b1;
  endtask

  task automatic test_single;
    logic [NREQ-1:0] got, eg;
    set_int(0, 2);
    step(4'b0001, 1'b0, got, eg);
    vectors++;
    if (got !== eg) begin
      miscompares++;
      $display("FAIL single_grant: req_ready=%b, required %b", got, eg);
    end
    req_valid = '0;
    #1;
    vectors++;
    if (cvt_int !== 32'hFFFF_F884) begin
      miscompares++;
      $display("FAIL single_cvt_int: cvt_int=%h, required fffff884", cvt_int);
    end
    wait_drain("single");
  endtask

  task automatic test_all_four;
    logic [NREQ-1:0] got, eg;
    for (int r = 0; r < NREQ; r++) set_int(r, r);
    for (int n = 0; n < 5; n++) begin
      step(4'b1111, 1'b0, got, eg);
      vectors++;
      if (got !== eg) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: req_ready=%b, required %b", n, got, eg);
      end
    end
    wait_drain("all_four");
  endtask

  task automatic test_wrap;
    logic [NREQ-1:0] got, eg;
    logic [NREQ-1:0] want [3] = '{4'b0100, 4'b1000, 4'b0010};
    logic [NREQ-1:0] vpat [3] = '{4'b0100, 4'b1010, 4'b1010};
    set_int(1, 9);
    set_int(2, 10);
    set_int(3, 11);
    for (int n = 0; n < 3; n++) begin
      step(vpat[n], 1'b0, got, eg);
      vectors++;
      if (got !== want[n] || got !== eg) begin
        miscompares++;
        $display("FAIL wrap_grant[%0d]: req_ready=%b, required %b", n, got, want[n]);
      end
    end
    wait_drain("wrap");
  endtask

  task automatic test_hold;
    logic [NREQ-1:0] got, eg;
    bit done;
    for (int r = 0; r < NREQ; r++) set_int(r, r + 8);
    for (int n = 0; n < 2; n++) begin
      step(4'b1111, 1'b0, got, eg);
      vectors++;
      if (got !== eg) begin
        miscompares++;
        $display("FAIL hold_pre_grant[%0d]: req_ready=%b, required %b", n, got, eg);
      end
    end
    done = 1'b0;
    for (int n = 0; n < 4 * LAT && !done; n++) begin
      step(4'b1111, 1'b1, got, eg);
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("FAIL hold_ready[%0d]: req_ready=%b, required 0000", n, got);
      end
      #1;
      if (sb.size() == 0 && rsp_valid !== '0) begin
        @(negedge clk);
        #1;
        vectors++;
        if (idle !== 1'b1) begin
          miscompares++;
          $display("FAIL hold_idle: idle=%b after last response, required 1", idle);
        end
        done = 1'b1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL hold_drain: last response not seen, %0d outstanding", sb.size());
      sb.delete();
    end
    hold = 1'b0;
    wait_drain("hold");
  endtask

  task automatic test_reset_mid;
    logic [NREQ-1:0] got, eg;
    for (int r = 0; r < NREQ; r++) set_int(r, NREQ - 1 - r);
    for (int n = 0; n < 2; n++) begin
      step(4'b1111, 1'b0, got, eg);
      vectors++;
      if (got !== eg) begin
        miscompares++;
        $display("FAIL midrst_grant[%0d]: req_ready=%b, required %b", n, got, eg);
      end
    end
    // A third request is pending while reset lands; it must not be granted.
    reset = 1'b1;
    #1;
    vectors++;
    if (req_ready !== '0) begin
      miscompares++;
      $display("FAIL midrst_ready: req_ready=%b during reset, required 0000", req_ready);
    end
    sb.delete();
    model_ptr = 0;
    model_cvt = '0;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    #1;
    vectors++;
    if (idle !== 1'b1 || cvt_int !== '0 || rsp_valid !== '0) begin
      miscompares++;
      $display("FAIL midrst_state: idle=%b cvt_int=%h rsp_valid=%b, required 1/0/0000",
               idle, cvt_int, rsp_valid);
    end
    repeat (LAT + 3) @(negedge clk);
    step(4'b1111, 1'b0, got, eg);
    vectors++;
    if (got !== 4'b0001 || got !== eg) begin
      miscompares++;
      $display("FAIL midrst_ptr: first grant after reset %b, required 0001", got);
    end
    wait_drain("midrst");
  endtask

  task automatic test_no_requests;
    logic [NREQ-1:0] got, eg;
    for (int n = 0; n < 10; n++) begin
      step('0, 1'b0, got, eg);
      #1;
      vectors++;
      if (got !== eg || rsp_valid !== '0 || idle !== 1'b1 || cvt_int !== model_cvt) begin
        miscompares++;
        $display("FAIL idle_cycle[%0d]: ready=%b rsp_valid=%b idle=%b cvt_int=%h, required 0000/0000/1/%h",
                 n, got, rsp_valid, idle, cvt_int, model_cvt);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [NREQ-1:0] got, eg;
    logic [NREQ-1:0] v;
    logic            h;
    for (int r = 0; r < NREQ; r++) set_int(r, r + 4);
    for (int n = 0; n < 8; n++) begin
      step(4'b1111, 1'b0, got, eg);
      vectors++;
      if (got !== eg) begin
        miscompares++;
        $display("FAIL b2b_grant[%0d]: req_ready=%b, required %b", n, got, eg);
      end
    end
    for (int n = 0; n < 60; n++) begin
      v = NREQ'($urandom);
      h = ($urandom_range(0, 7) == 0);
      step(v, h, got, eg);
      vectors++;
      if (got !== eg) begin
        miscompares++;
        $display("FAIL rand_grant[%0d]: valid=%b hold=%b req_ready=%b, required %b", n, v, h, got, eg);
      end
      for (int r = 0; r < NREQ; r++) begin
        if (eg[r]) set_int(r, int'($urandom_range(0, NTAB - 1)));
      end
    end
    hold = 1'b0;
    wait_drain("b2b");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_no_requests();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
